// File: rtl/watch_set_ctrl.sv
// Watch time-set sequencer: turns the 1 Hz tick into carry pulses in RUN, and
// steps one frozen field per button press (with auto-repeat, blink, timeout) in SET.
module watch_set_ctrl #(
  parameter int DATA_W      = 6,
  parameter int SEC_MAX     = 59,
  parameter int MIN_MAX     = 59,
  parameter int REPEAT_DLY  = 500,
  parameter int REPEAT_PER  = 100,
  parameter int TIMEOUT_CYC = 5000,
  parameter int BLINK_HALF  = 250
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick_1hz,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic [DATA_W-1:0] sec_val,
  input  logic [DATA_W-1:0] min_val,
  output logic              sec_pulse,
  output logic              min_pulse,
  output logic              hour_pulse,
  output logic              set_mode,
  output logic [1:0]        field_sel,
  output logic              blink
);

  localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam int BL_W    = $clog2(BLINK_HALF + 1);

  localparam logic [REP_W-1:0]  REP_FIRE   = REP_W'(REPEAT_DLY);
  localparam logic [REP_W-1:0]  REP_RELOAD = REP_W'(REPEAT_DLY - REPEAT_PER + 1);
  localparam logic [REP_W-1:0]  REP_ONE    = REP_W'(1);
  localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [BL_W-1:0]   BL_LAST    = BL_W'(BLINK_HALF - 1);
  localparam logic [DATA_W-1:0] SEC_TOP    = DATA_W'(SEC_MAX);
  localparam logic [DATA_W-1:0] MIN_TOP    = DATA_W'(MIN_MAX);

  // State encoding doubles as the field_sel code
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    SET_SEC  = 2'b11
  } state_t;

  state_t           state;
  state_t           nextState;
  logic             btnIncQ;
  logic             armed;
  logic [REP_W-1:0] repCnt;
  logic [TO_W-1:0]  toCnt;
  logic [BL_W-1:0]  blinkCnt;
  logic             blinkPhase;

  logic incEdge;
  logic inSet;
  logic repFire;
  logic incEvent;
  logic idleTimeout;
  logic stateChange;
  logic nextPhase;
  logic runTick;
  logic secCarry;
  logic minCarry;

  always_comb begin
    incEdge     = btn_inc & ~btnIncQ;
    inSet       = (state != RUN);
    repFire     = armed & btn_inc & (repCnt == REP_FIRE);
    incEvent    = inSet & ~btn_mode & (incEdge | repFire);
    idleTimeout = inSet & ~btn_mode & ~btn_inc & (toCnt == TO_LAST);
    runTick     = (state == RUN) & tick_1hz;
    secCarry    = runTick & (sec_val == SEC_TOP);
    minCarry    = secCarry & (min_val == MIN_TOP);

    nextState = state;
    if (btn_mode) begin
      case (state)
        RUN:      nextState = SET_HOUR;
        SET_HOUR: nextState = SET_MIN;
        SET_MIN:  nextState = SET_SEC;
        default:  nextState = RUN;
      endcase
    end else if (idleTimeout) begin
      nextState = RUN;
    end

    stateChange = (nextState != state);
    nextPhase   = blinkPhase;
    if (stateChange)
      nextPhase = 1'b0;
    else if (inSet && (blinkCnt == BL_LAST))
      nextPhase = ~blinkPhase;
  end

  // Repeat counter is armed only by a press made inside a SET state; a mode
  // change disarms it so a held button never leaks into the next field.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      btnIncQ    <= 1'b0;
      armed      <= 1'b0;
      repCnt     <= '0;
      toCnt      <= '0;
      blinkCnt   <= '0;
      blinkPhase <= 1'b0;
      sec_pulse  <= 1'b0;
      min_pulse  <= 1'b0;
      hour_pulse <= 1'b0;
      set_mode   <= 1'b0;
      field_sel  <= 2'b00;
      blink      <= 1'b0;
    end else begin
      state   <= nextState;
      btnIncQ <= btn_inc;

      sec_pulse  <= runTick  | (incEvent & (state == SET_SEC));
      min_pulse  <= secCarry | (incEvent & (state == SET_MIN));
      hour_pulse <= minCarry | (incEvent & (state == SET_HOUR));
      set_mode   <= (nextState != RUN);
      field_sel  <= nextState;
      blink      <= nextPhase & (nextState != RUN) & ~btn_inc;

      blinkPhase <= nextPhase;
      if (stateChange || !inSet || (blinkCnt == BL_LAST))
        blinkCnt <= '0;
      else
        blinkCnt <= blinkCnt + 1'b1;

      if (!inSet || btn_mode || btn_inc || idleTimeout)
        toCnt <= '0;
      else
        toCnt <= toCnt + 1'b1;

      // Reload after a repeat so the counter never exceeds REPEAT_DLY
      if (!btn_inc || btn_mode) begin
        armed  <= 1'b0;
        repCnt <= '0;
      end else if (incEdge && inSet) begin
        armed  <= 1'b1;
        repCnt <= REP_ONE;
      end else if (armed) begin
        if (repCnt == REP_FIRE)
          repCnt <= REP_RELOAD;
        else
          repCnt <= repCnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Self-checking bench for watch_set_ctrl: directed scenarios with literal
// expectations, then random stimulus against a cycle-count based reference model.
module tb_watch_set_ctrl;

  localparam int REPEAT_DLY  = 500;
  localparam int REPEAT_PER  = 100;
  localparam int TIMEOUT_CYC = 5000;
  localparam int BLINK_HALF  = 250;

  logic       clock    = 1'b0;
  logic       reset    = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc  = 1'b0;
  logic [5:0] sec_val  = 6'd0;
  logic [5:0] min_val  = 6'd0;
  logic       sec_pulse;
  logic       min_pulse;
  logic       hour_pulse;
  logic       set_mode;
  logic [1:0] field_sel;
  logic       blink;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clock = ~clock;

  watch_set_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .tick_1hz   (tick_1hz),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .sec_val    (sec_val),
    .min_val    (min_val),
    .sec_pulse  (sec_pulse),
    .min_pulse  (min_pulse),
    .hour_pulse (hour_pulse),
    .set_mode   (set_mode),
    .field_sel  (field_sel),
    .blink      (blink)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: mode index, idle/age/hold lengths in plain cycle counts
  int mMode  = 0;
  int mOld   = 0;
  int mIdle  = 0;
  int mAge   = 0;
  int mSince = 0;
  int mK     = 0;
  bit mArmed   = 1'b0;
  bit mPrevInc = 1'b0;
  bit mEdge    = 1'b0;
  bit mInc     = 1'b0;
  bit mChanged = 1'b0;
  bit mReady   = 1'b0;
  bit eSec = 1'b0, eMin = 1'b0, eHour = 1'b0, eSet = 1'b0, eBlink = 1'b0;
  int eField = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mMode = 0; mIdle = 0; mAge = 0; mSince = 0;
      mArmed = 1'b0; mPrevInc = 1'b0;
      eSec = 1'b0; eMin = 1'b0; eHour = 1'b0; eSet = 1'b0; eBlink = 1'b0; eField = 0;
      mReady = 1'b1;
    end else begin
      mOld  = mMode;
      mEdge = btn_inc && !mPrevInc;
      eSec = 1'b0; eMin = 1'b0; eHour = 1'b0;
      if (mMode == 0) begin
        if (tick_1hz) begin
          eSec  = 1'b1;
          eMin  = (sec_val == 6'd59);
          eHour = (sec_val == 6'd59) && (min_val == 6'd59);
        end
      end else if (!btn_mode) begin
        mK   = mSince + 1;
        mInc = mEdge || (mArmed && btn_inc && mK >= REPEAT_DLY &&
                         ((mK - REPEAT_DLY) % REPEAT_PER) == 0);
        if (mInc) begin
          if (mMode == 1) eHour = 1'b1;
          if (mMode == 2) eMin  = 1'b1;
          if (mMode == 3) eSec  = 1'b1;
        end
      end

      mChanged = 1'b0;
      if (btn_mode) begin
        mMode = (mMode + 1) % 4;
        mIdle = 0;
        mChanged = 1'b1;
      end else if (mMode != 0) begin
        if (btn_inc) mIdle = 0;
        else begin
          mIdle++;
          if (mIdle == TIMEOUT_CYC) begin
            mMode = 0; mIdle = 0; mChanged = 1'b1;
          end
        end
      end

      if (!btn_inc || btn_mode) mArmed = 1'b0;
      else if (mEdge && mOld != 0) begin
        mArmed = 1'b1; mSince = 0;
      end else if (mArmed) mSince = mSince + 1;

      if (mChanged) mAge = 0;
      else if (mMode != 0) mAge++;

      eSet   = (mMode != 0);
      eField = mMode;
      eBlink = (mMode != 0) && !btn_inc && (((mAge / BLINK_HALF) % 2) == 1);
      mPrevInc = btn_inc;
    end
  end

  always @(negedge clock) begin
    if (!reset && mReady) begin
      checkOutput("cmp_sec_pulse",  int'(sec_pulse),  int'(eSec));
      checkOutput("cmp_min_pulse",  int'(min_pulse),  int'(eMin));
      checkOutput("cmp_hour_pulse", int'(hour_pulse), int'(eHour));
      checkOutput("cmp_set_mode",   int'(set_mode),   int'(eSet));
      checkOutput("cmp_field_sel",  int'(field_sel),  eField);
      checkOutput("cmp_blink",      int'(blink),      int'(eBlink));
    end
  end

  task automatic applyStimulus(input bit t, input bit m, input bit i,
                               input logic [5:0] s, input logic [5:0] mi);
    @(negedge clock);
    tick_1hz = t; btn_mode = m; btn_inc = i; sec_val = s; min_val = mi;
  endtask

  task automatic pulseMode();
    applyStimulus(1'b0, 1'b1, 1'b0, sec_val, min_val);
    applyStimulus(1'b0, 1'b0, 1'b0, sec_val, min_val);
  endtask

  int pc;
  int holdLeft;

  initial begin
    repeat (3) @(negedge clock);
    checkOutput("reset_sec",   int'(sec_pulse), 0);
    checkOutput("reset_set",   int'(set_mode),  0);
    checkOutput("reset_field", int'(field_sel), 0);
    checkOutput("reset_blink", int'(blink),     0);
    reset = 1'b0;

    // Full carry from 59:59
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd59, 6'd59);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd59, 6'd59);
    checkOutput("carry_sec",  int'(sec_pulse),  1);
    checkOutput("carry_min",  int'(min_pulse),  1);
    checkOutput("carry_hour", int'(hour_pulse), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd30, 6'd0);
    checkOutput("carry_end_sec",  int'(sec_pulse),  0);
    checkOutput("carry_end_hour", int'(hour_pulse), 0);

    // Plain tick, then btn_inc ignored in RUN
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd30, 6'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd30, 6'd0);
    checkOutput("tick30_sec", int'(sec_pulse), 1);
    checkOutput("tick30_min", int'(min_pulse), 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'd30, 6'd0);
    pc = 0;
    repeat (1000) begin
      @(negedge clock);
      pc += int'(sec_pulse) + int'(min_pulse) + int'(hour_pulse);
    end
    btn_inc = 1'b0;
    checkOutput("run_inc_ignored", pc, 0);

    // SET_MIN single press, tick frozen
    pulseMode();
    pulseMode();
    checkOutput("setmin_field", int'(field_sel), 2);
    checkOutput("setmin_mode",  int'(set_mode),  1);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'd30, 6'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd30, 6'd0);
    checkOutput("setmin_pulse", int'(min_pulse),  1);
    checkOutput("setmin_hour",  int'(hour_pulse), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd59, 6'd59);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd59, 6'd59);
    checkOutput("setmin_tick_sec", int'(sec_pulse), 0);
    checkOutput("setmin_tick_min", int'(min_pulse), 0);

    // SET_HOUR auto-repeat over an 800-cycle hold
    pulseMode();
    pulseMode();
    pulseMode();
    checkOutput("sethour_field", int'(field_sel), 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'd0, 6'd0);
    pc = 0;
    for (int i = 1; i <= 800; i++) begin
      @(negedge clock);
      if (hour_pulse) pc++;
      if (i == 1 || i == 501 || i == 601 || i == 701)
        checkOutput($sformatf("repeat_at_%0d", i), int'(hour_pulse), 1);
      if (i == 500 || i == 502)
        checkOutput($sformatf("repeat_gap_%0d", i), int'(hour_pulse), 0);
    end
    btn_inc = 1'b0;
    repeat (5) begin
      @(negedge clock);
      if (hour_pulse) pc++;
    end
    checkOutput("repeat_total", pc, 4);

    // SET_SEC timeout boundary
    pulseMode();
    pulseMode();
    checkOutput("setsec_field", int'(field_sel), 3);
    repeat (TIMEOUT_CYC - 1) @(negedge clock);
    checkOutput("timeout_not_yet", int'(set_mode), 1);
    @(negedge clock);
    checkOutput("timeout_set",   int'(set_mode),  0);
    checkOutput("timeout_field", int'(field_sel), 0);
    checkOutput("timeout_blink", int'(blink),     0);

    // Mode beats a simultaneous press; held button does not follow the field
    pulseMode();
    applyStimulus(1'b0, 1'b1, 1'b1, 6'd0, 6'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'd0, 6'd0);
    checkOutput("collide_field", int'(field_sel),  2);
    checkOutput("collide_min",   int'(min_pulse),  0);
    checkOutput("collide_hour",  int'(hour_pulse), 0);
    pc = 0;
    repeat (600) begin
      @(negedge clock);
      pc += int'(min_pulse);
    end
    checkOutput("held_no_repeat", pc, 0);
    btn_inc = 1'b0;
    @(negedge clock);
    btn_inc = 1'b1;
    pc = 0;
    repeat (550) begin
      @(negedge clock);
      pc += int'(min_pulse);
    end
    checkOutput("repress_pulses", pc, 2);
    reset = 1'b1;
    #1;
    checkOutput("midrst_set",   int'(set_mode),  0);
    checkOutput("midrst_field", int'(field_sel), 0);
    checkOutput("midrst_min",   int'(min_pulse), 0);
    checkOutput("midrst_blink", int'(blink),     0);
    btn_inc = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    pc = 0;
    repeat (20) begin
      @(negedge clock);
      pc += int'(sec_pulse) + int'(min_pulse) + int'(hour_pulse);
    end
    checkOutput("post_reset_quiet", pc, 0);

    // Random phase against the model
    holdLeft = 0;
    repeat (15000) begin
      @(negedge clock);
      tick_1hz = ($urandom_range(0, 39) == 0);
      btn_mode = ($urandom_range(0, 299) == 0);
      if (holdLeft == 0) begin
        btn_inc  = $urandom_range(0, 1) == 1;
        holdLeft = int'($urandom_range(1, 900));
      end else holdLeft--;
      sec_val = ($urandom_range(0, 3) == 0) ? 6'd59 : 6'($urandom_range(0, 59));
      min_val = ($urandom_range(0, 3) == 0) ? 6'd59 : 6'($urandom_range(0, 59));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 6'd0);
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
